pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Lock-qualified reset generator that sits directly after a PLL primitive wrapper. It synchronizes the PLL `locked` flag into the design clock domain and filters it for stability. It then holds the downstream logic in reset for a fixed number of cycles before releasing it. It re-asserts reset when lock is lost for long enough, and counts those loss events for debug.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages in the `locked` synchronizer; legal range 2..4.
- `LOCK_FILTER`, 16: consecutive synchronized-high samples required before lock is trusted; ≥1.
- `HOLD_CYCLES`, 256: cycles reset stays asserted after lock is trusted; ≥1.
- `LOSS_FILTER`, 4: consecutive synchronized-low samples in RUN that count as a lock loss; ≥1.

Ports:
- `clock` input 1: design clock, normally a PLL output.
- `reset` input 1: asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `locked` input 1: raw PLL lock flag, asynchronous to `clock`.
- `rst_out` output 1: active-high reset for downstream logic; registered.
- `ready` output 1: registered complement of `rst_out`.
- `state` output 2: current state; 0=WAIT_LOCK, 1=FILTER, 2=HOLD, 3=RUN.
- `loss_count` output 8: number of RUN→WAIT_LOCK lock losses; saturates at 255.

## Operation
- Synchronizer: a chain of `SYNC_STAGES` flops; its last stage is `locked_s`. No other logic reads `locked` directly.
- One shared counter `cnt`, sized `$clog2(max(LOCK_FILTER, HOLD_CYCLES, LOSS_FILTER)+1)` bits. It is cleared on every state change.
- WAIT_LOCK:
  - If `locked_s`=1: go to FILTER with `cnt`=1.
  - If `LOCK_FILTER`=1: go straight to HOLD instead.
- FILTER:
  - If `locked_s`=0: go to WAIT_LOCK.
  - Otherwise increment `cnt`. When the incremented value equals `LOCK_FILTER`, go to HOLD with `cnt`=0.
- HOLD:
  - If `locked_s`=0: go to WAIT_LOCK. This is not counted as a loss.
  - Otherwise increment `cnt`. When the incremented value equals `HOLD_CYCLES`, go to RUN.
- RUN:
  - Each cycle `locked_s`=0 increments `cnt`. Any cycle with `locked_s`=1 clears `cnt`, so a glitch shorter than `LOSS_FILTER` samples is ignored.
  - When the incremented value equals `LOSS_FILTER`: go to WAIT_LOCK and increment `loss_count` unless it is already 255.
- `rst_out` and `ready` are flops loaded from the next state. On the edge that enters RUN, `rst_out` becomes 0. On the edge that leaves RUN, `rst_out` becomes 1. Both outputs are glitch-free.
- `reset` asserted, at any time including mid-HOLD or in RUN:
  - Immediately (asynchronously) sets synchronizer flops = 0, state = WAIT_LOCK, `cnt` = 0, `rst_out` = 1, `ready` = 0, `loss_count` = 0.
- After `reset` deasserts, the block restarts from WAIT_LOCK. `locked` already being high is handled like a fresh rise.

## Timing
- Reset values: `rst_out`=1, `ready`=0, `state`=0, `loss_count`=0.
- `locked_s` follows `locked` with a latency of `SYNC_STAGES` rising edges.
- Lock-up latency: `locked` rises between edges and stays high. `rst_out` falls on rising edge number `SYNC_STAGES + LOCK_FILTER + HOLD_CYCLES` after the rise; edge 1 is the first edge that captures it. Defaults give 274.
- Loss latency: `locked` falls in RUN and stays low. `rst_out` rises on edge `SYNC_STAGES + LOSS_FILTER` after the fall. `loss_count` updates on that same edge.
- A low pulse on `locked` lasting L edges (L < `LOSS_FILTER`) while in RUN: `rst_out` remains 0.
- A low on `locked_s` during FILTER or HOLD restarts the whole qualification from WAIT_LOCK.
- Simultaneous `locked_s` return-high and `cnt` reaching `LOSS_FILTER` cannot occur: both are evaluated on the same sampled value.

## Test plan
- Defaults, `reset` released, `locked` high from 3 cycles later:
  - `rst_out` falls exactly 274 edges after the `locked` rise.
  - `state` steps 0→1→2→3.
  - `loss_count`=0.
- `LOCK_FILTER`=4, `HOLD_CYCLES`=8:
  - `locked` drops for 1 cycle during FILTER: state returns to 0, `loss_count` stays 0.
  - After `locked` is restored, `rst_out` falls 14 edges after the final rise.
- In RUN with `LOSS_FILTER`=4:
  - 3-cycle low pulse on `locked`: `rst_out` stays 0.
  - 6-cycle low pulse: `rst_out`=1 on edge 6 after the fall, `loss_count`=1, then reacquisition.
- 300 forced lock-loss events: `loss_count` saturates at 255 and does not wrap.
- `reset` asserted asynchronously mid-HOLD and in RUN:
  - All outputs take their reset values before the next edge.
  - After release with `locked` held high, the full 274-edge sequence repeats.
- `LOCK_FILTER`=1, `HOLD_CYCLES`=1, `SYNC_STAGES`=3: `rst_out` falls 5 edges after the `locked` rise.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: lock-qualified reset generator behind a PLL wrapper.
// Synchronizes and filters `locked`, holds reset, and counts lock losses.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 256,
  parameter int LOSS_FILTER = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  output logic       rst_out,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] loss_count
);

  localparam int MAX_AB =
    (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int MAX_N =
    (MAX_AB > LOSS_FILTER) ? MAX_AB : LOSS_FILTER;
  localparam int CW = $clog2(MAX_N + 1);

  localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FILTER);
  localparam logic [CW-1:0] HOLD_N = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] LOSS_N = CW'(LOSS_FILTER);
  localparam logic [CW-1:0] ONE_N  = CW'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t cur;
  state_t nxt;

  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_n;
  logic [CW-1:0]          cnt_inc;
  logic                   loss_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], locked};
    end
  end

  assign locked_s = sync[SYNC_STAGES-1];
  assign cnt_inc  = cnt + ONE_N;

  always_comb begin
    nxt      = cur;
    cnt_n    = cnt;
    loss_hit = 1'b0;
    unique case (cur)
      WAIT_LOCK: begin
        if (locked_s) begin
          // a single-sample filter is already satisfied by this sample
          if (LOCK_FILTER == 1) begin
            nxt   = HOLD;
            cnt_n = '0;
          end else begin
            nxt   = FILTER;
            cnt_n = ONE_N;
          end
        end
      end
      FILTER: begin
        if (!locked_s) begin
          nxt   = WAIT_LOCK;
          cnt_n = '0;
        end else if (cnt_inc == LOCK_N) begin
          nxt   = HOLD;
          cnt_n = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          nxt   = WAIT_LOCK;
          cnt_n = '0;
        end else if (cnt_inc == HOLD_N) begin
          nxt   = RUN;
          cnt_n = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      RUN: begin
        if (locked_s) begin
          cnt_n = '0;
        end else if (cnt_inc == LOSS_N) begin
          nxt      = WAIT_LOCK;
          cnt_n    = '0;
          loss_hit = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        nxt   = WAIT_LOCK;
        cnt_n = '0;
      end
    endcase
  end

  // outputs load from the next state so they switch on the transition edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur        <= WAIT_LOCK;
      cnt        <= '0;
      rst_out    <= 1'b1;
      ready      <= 1'b0;
      loss_count <= 8'd0;
    end else begin
      cur     <= nxt;
      cnt     <= cnt_n;
      rst_out <= (nxt != RUN);
      ready   <= (nxt == RUN);
      if (loss_hit && (loss_count != 8'hFF)) begin
        loss_count <= loss_count + 8'd1;
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: three parameter sets on one lock stimulus,
// scored every cycle against a run-length reference model.
module tb_pll_reset_sequencer;

  logic clock  = 1'b0;
  logic reset  = 1'b0;
  logic locked = 1'b0;

  logic       rst_o [3];
  logic       rdy_o [3];
  logic [1:0] st_o  [3];
  logic [7:0] lc_o  [3];

  int checks = 0;
  int errors = 0;

  int P_S    [3] = '{2, 2, 3};
  int P_LF   [3] = '{16, 4, 1};
  int P_HC   [3] = '{256, 8, 1};
  int P_LOSS [3] = '{4, 4, 4};

  int lat [3];

  always #5 clock = ~clock;

  pll_reset_sequencer #(
    .SYNC_STAGES(2), .LOCK_FILTER(16),
    .HOLD_CYCLES(256), .LOSS_FILTER(4)
  ) u_def (
    .clock(clock), .reset(reset), .locked(locked),
    .rst_out(rst_o[0]), .ready(rdy_o[0]),
    .state(st_o[0]), .loss_count(lc_o[0])
  );

  pll_reset_sequencer #(
    .SYNC_STAGES(2), .LOCK_FILTER(4),
    .HOLD_CYCLES(8), .LOSS_FILTER(4)
  ) u_small (
    .clock(clock), .reset(reset), .locked(locked),
    .rst_out(rst_o[1]), .ready(rdy_o[1]),
    .state(st_o[1]), .loss_count(lc_o[1])
  );

  pll_reset_sequencer #(
    .SYNC_STAGES(3), .LOCK_FILTER(1),
    .HOLD_CYCLES(1), .LOSS_FILTER(4)
  ) u_min (
    .clock(clock), .reset(reset), .locked(locked),
    .rst_out(rst_o[2]), .ready(rdy_o[2]),
    .state(st_o[2]), .loss_count(lc_o[2])
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: raw lock history delayed by the sync depth, then a count of
  // consecutive trusted-high samples (qh) and of low samples while running.
  bit hist [$];
  int qh    [3] = '{0, 0, 0};
  int lowr  [3] = '{0, 0, 0};
  int loss  [3] = '{0, 0, 0};
  bit run   [3] = '{0, 0, 0};

  task automatic model_clear();
    hist.delete();
    for (int k = 0; k < 3; k++) begin
      qh[k] = 0; lowr[k] = 0; loss[k] = 0; run[k] = 0;
    end
  endtask

  task automatic model_step();
    bit ls;
    for (int k = 0; k < 3; k++) begin
      ls = 1'b0;
      if (hist.size() >= P_S[k]) ls = hist[hist.size() - P_S[k]];
      if (run[k]) begin
        if (!ls) begin
          lowr[k]++;
          if (lowr[k] == P_LOSS[k]) begin
            run[k] = 0; qh[k] = 0; lowr[k] = 0;
            if (loss[k] < 255) loss[k]++;
          end
        end else begin
          lowr[k] = 0;
        end
      end else if (ls) begin
        qh[k]++;
        if (qh[k] == P_LF[k] + P_HC[k]) begin
          run[k] = 1; lowr[k] = 0;
        end
      end else begin
        qh[k] = 0;
      end
    end
    hist.push_back(locked);
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  function automatic int exp_state(input int k);
    if (run[k]) return 3;
    if (qh[k] == 0) return 0;
    if (qh[k] < P_LF[k]) return 1;
    return 2;
  endfunction

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) model_clear();
    else model_step();
  end

  initial forever begin
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sb_rst%0d", k), int'(rst_o[k]), int'(!run[k]));
      chk($sformatf("sb_rdy%0d", k), int'(rdy_o[k]), int'(run[k]));
      chk($sformatf("sb_st%0d", k), int'(st_o[k]), exp_state(k));
      chk($sformatf("sb_lc%0d", k), int'(lc_o[k]), loss[k]);
    end
  end

  task automatic chk_reset_vals(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_rst%0d", tag, k), int'(rst_o[k]), 1);
      chk($sformatf("%s_rdy%0d", tag, k), int'(rdy_o[k]), 0);
      chk($sformatf("%s_st%0d", tag, k), int'(st_o[k]), 0);
      chk($sformatf("%s_lc%0d", tag, k), int'(lc_o[k]), 0);
    end
  endtask

  // edge index (1-based) at which each rst_out first shows val; -1 if never
  task automatic measure(input int limit, input logic val);
    for (int k = 0; k < 3; k++) lat[k] = -1;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clock);
      #1;
      for (int k = 0; k < 3; k++)
        if (lat[k] < 0 && rst_o[k] == val) lat[k] = n;
    end
  endtask

  task automatic chk_lockup(input string tag);
    chk({tag, "_lat0"}, lat[0], 274);
    chk({tag, "_lat1"}, lat[1], 14);
    chk({tag, "_lat2"}, lat[2], 5);
  endtask

  task automatic hold_locked(input bit v, input int n);
    locked = v;
    repeat (n) @(negedge clock);
  endtask

  int lc_keep;
  int hi_len;

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    chk_reset_vals("por");
    #1 reset = 1'b0;

    repeat (3) @(negedge clock);
    locked = 1'b1;
    measure(300, 1'b0);
    chk_lockup("up");
    for (int k = 0; k < 3; k++)
      chk($sformatf("up_lc%0d", k), int'(lc_o[k]), 0);

    @(negedge clock);
    hold_locked(1'b0, 3);
    hold_locked(1'b1, 10);
    for (int k = 0; k < 3; k++)
      chk($sformatf("glitch_rst%0d", k), int'(rst_o[k]), 0);

    locked = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clock);
      #1;
      if (n == 5) chk("loss_e5", int'(rst_o[1]), 0);
      if (n == 6) begin
        chk("loss_rst0", int'(rst_o[0]), 1);
        chk("loss_rst1", int'(rst_o[1]), 1);
        chk("loss_lc0", int'(lc_o[0]), 1);
        chk("loss_lc1", int'(lc_o[1]), 1);
      end
    end
    @(negedge clock);
    locked = 1'b1;
    measure(300, 1'b0);
    chk_lockup("reacq");

    @(negedge clock);
    hold_locked(1'b0, 10);
    hold_locked(1'b1, 100);
    chk("hold_st0", int'(st_o[0]), 2);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async");
    @(negedge clock);
    #1 reset = 1'b0;
    measure(300, 1'b0);
    chk_lockup("rel");

    @(negedge clock);
    hold_locked(1'b0, 8);
    lc_keep = int'(lc_o[1]);
    hold_locked(1'b1, 2);
    hold_locked(1'b0, 1);
    locked = 1'b1;
    measure(300, 1'b0);
    chk("filt_lat0", lat[0], 274);
    chk("filt_lat1", lat[1], 14);
    chk("filt_lc1", int'(lc_o[1]), lc_keep);

    @(negedge clock);
    for (int e = 1; e <= 300; e++) begin
      hold_locked(1'b0, 7);
      hold_locked(1'b1, 18);
      if (e == 260) begin
        chk("sat260_lc1", int'(lc_o[1]), 255);
        chk("sat260_lc2", int'(lc_o[2]), 255);
      end
    end
    chk("sat_lc1", int'(lc_o[1]), 255);
    chk("sat_lc2", int'(lc_o[2]), 255);

    for (int s = 0; s < 40; s++) begin
      hi_len = ($urandom_range(0, 3) == 0) ? 300 : $urandom_range(1, 20);
      hold_locked(1'b1, hi_len);
      hold_locked(1'b0, $urandom_range(1, 10));
      if ($urandom_range(0, 7) == 0) begin
        locked = 1'($urandom_range(0, 1));
        @(posedge clock);
        #($urandom_range(1, 3)) reset = 1'b1;
        #1 chk_reset_vals("rnd_async");
        @(negedge clock);
        #1 reset = 1'b0;
      end
    end
    hold_locked(1'b1, 290);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
